// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Program-counter owner and fetch sequencer for the 9-bit ISA.
//               Stalls on data-memory accesses, resolves branches through a
//               programmable 16-entry target LUT and qualifies all commits.
//               Optional performance counters: define SEQ_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int          PC_W      = 10,
    parameter int          LUT_DEPTH = 16,
    parameter logic [8:0]  HALT_CODE = 9'b001111111
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [8:0]      instr,
    input  logic [1:0]      branch,
    input  logic [3:0]      target_lut,
    input  logic            load_mem,
    input  logic            store_mem,
    input  logic            cond_flag,
    input  logic            mem_ready,
    input  logic            lut_wr_en,
    input  logic [3:0]      lut_wr_idx,
    input  logic [PC_W-1:0] lut_wr_data,
    output logic [PC_W-1:0] pc,
    output logic            mem_req,
    output logic            commit_en,
    output logic            busy,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instr_cnt,
`endif
    output logic            done
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_EXEC     = 2'd1;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] c_ST_HALT     = 2'd3;

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] lut_q [LUT_DEPTH];
    logic [PC_W-1:0] lut_d [LUT_DEPTH];

    logic            w_is_halt;
    logic            w_is_mem;
    logic            w_br_taken;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_lut_rd;

    assign w_is_halt = (instr == HALT_CODE);
    assign w_is_mem  = load_mem | store_mem;
    assign w_pc_inc  = pc_q + PC_W'(1);
    // Reads come from the registered table, so a same-cycle write is seen next cycle.
    assign w_lut_rd  = lut_q[target_lut];

    always_comb begin
        w_br_taken = 1'b0;
        unique case (branch)
            2'b00:   w_br_taken = 1'b0;
            2'b01:   w_br_taken = cond_flag;
            2'b10:   w_br_taken = ~cond_flag;
            default: w_br_taken = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-pc logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            c_ST_IDLE: begin
                if (start) begin
                    state_d = c_ST_EXEC;
                    pc_d    = '0;
                end
            end
            c_ST_EXEC: begin
                if (w_is_halt) begin
                    state_d = c_ST_HALT;
                end else if (w_is_mem) begin
                    state_d = c_ST_MEM_WAIT;
                end else if (w_br_taken) begin
                    pc_d = w_lut_rd;
                end else begin
                    pc_d = w_pc_inc;
                end
            end
            c_ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = c_ST_EXEC;
                    pc_d    = w_pc_inc;
                end
            end
            c_ST_HALT: begin
                if (start) begin
                    state_d = c_ST_EXEC;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (mem_req rises combinationally in the issuing cycle)
    // ------------------------------------------------------------------
    always_comb begin
        mem_req   = 1'b0;
        commit_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            c_ST_EXEC: begin
                busy      = 1'b1;
                mem_req   = ~w_is_halt & w_is_mem;
                commit_en = ~w_is_halt & ~w_is_mem;
            end
            c_ST_MEM_WAIT: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                commit_en = mem_ready;
            end
            c_ST_HALT: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign pc = pc_q;

    // ------------------------------------------------------------------
    // Branch-target LUT, writable in every state
    // ------------------------------------------------------------------
    always_comb begin
        lut_d = lut_q;
        if (lut_wr_en) begin
            lut_d[lut_wr_idx] = lut_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            lut_q <= lut_d;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] cycle_cnt_d;
    logic [31:0] instr_cnt_q;
    logic [31:0] instr_cnt_d;
    logic        w_start_acc;
    logic        w_instr_evt;

    assign w_start_acc = start & ((state_q == c_ST_IDLE) | (state_q == c_ST_HALT));
    assign w_instr_evt = commit_en | ((state_q == c_ST_EXEC) & (branch != 2'b00));

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (w_start_acc) begin
            cycle_cnt_d = '0;
            instr_cnt_d = '0;
        end else begin
            // Both counters saturate rather than wrap.
            if (busy && (cycle_cnt_q != '1)) begin
                cycle_cnt_d = cycle_cnt_q + 32'd1;
            end
            if (w_instr_evt && (instr_cnt_q != '1)) begin
                instr_cnt_d = instr_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle sequencer that owns the program counter and drives instruction fetch for the 9-bit ISA.
- Consumes the control decoder's branch, target-LUT and memory outputs.
- Stalls the core on data-memory accesses and resolves jumps through a programmable 16-entry branch-target LUT.
- Sits between the instruction ROM / control decoder and the register file / data memory; gates all architectural commits.

Parameters:
PC_W, 10, program counter width in bits (instruction ROM depth 2^PC_W)
LUT_DEPTH, 16, branch-target LUT entries (index width 4)
HALT_CODE, 9'b001111111, reserved no-op encoding that stops execution

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse: begin execution at pc 0
instr  in  9  instruction currently addressed by pc (combinational ROM read)
branch  in  2  decoder branch code: 00 none, 01 jump if flag, 10 jump if !flag, 11 unconditional
target_lut  in  4  decoder LUT index for branches
load_mem  in  1  decoder: current instruction is a load
store_mem  in  1  decoder: current instruction is a store
cond_flag  in  1  ALU condition flag, valid while the instruction executes
mem_ready  in  1  data memory completion for the outstanding request
lut_wr_en  in  1  write enable for the branch-target LUT
lut_wr_idx  in  4  LUT write index
lut_wr_data  in  PC_W  LUT write value (absolute target pc)
pc  out  PC_W  program counter / ROM address
mem_req  out  1  data memory request, held until mem_ready
commit_en  out  1  qualifies regWrite/storeMem commit this cycle
busy  out  1  state is EXEC or MEM_WAIT
done  out  1  state is HALT

Behaviour:
- Reset (async, any state): state=IDLE, pc=0, mem_req=0, commit_en=0, busy=0, done=0, all LUT entries=0.
- State IDLE:
  - start=1 -> pc=0, go EXEC. Otherwise stay.
  - The LUT is writable in every state.
- State EXEC, one instruction per cycle:
  - instr==HALT_CODE -> commit_en=0, pc holds, next state HALT.
  - load_mem or store_mem -> commit_en=0, mem_req=1 in the same cycle, next state MEM_WAIT, pc holds.
  - branch taken -> commit_en=1, pc <= lut[target_lut]. Taken means: 11 always; 01 when cond_flag=1; 10 when cond_flag=0.
  - All other instructions, including untaken branches -> commit_en=1, pc <= pc+1.
- State MEM_WAIT:
  - mem_req stays 1 and pc is stable while mem_ready=0.
  - On mem_ready=1: commit_en=1 and mem_req=1 for that cycle, pc <= pc+1, next EXEC.
  - mem_ready sampled in the same cycle mem_req first rises is ignored. Minimum access is 2 cycles.
- State HALT: done=1, pc frozen. start=1 -> pc=0, done drops the next cycle, go EXEC.
- start is ignored in EXEC and MEM_WAIT.
- pc increment wraps modulo 2^PC_W (max -> 0), with no flag.
- LUT read is combinational. A write to an index in the same cycle that index is read returns the old value; the new value is visible the next cycle.
- Branch latency 0: the target instruction executes in the cycle after the branch.
- Reset asserted mid-MEM_WAIT abandons the request: mem_req drops immediately.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[31:0] and instr_cnt[31:0], both reset to 0 and cleared on every start.
  - cycle_cnt increments every cycle while busy=1.
  - instr_cnt increments on every commit_en=1 cycle and on a taken or untaken branch.
  - Both counters saturate at all-ones.
- Not defined: no counter ports or logic exist.

Test Plan:
- Reset then start; ROM holds 5 ALU ops then HALT_CODE at pc 5 -> pc steps 0..5, commit_en=1 for 5 cycles, done=1 from the cycle after pc=5, pc stays 5.
- LUT[3]=0x040; at pc 2 branch=11, target_lut=3 -> next pc=0x040, commit_en=1 on the branch cycle.
- branch=01 at pc 7: cond_flag=0 -> pc 8; rerun with cond_flag=1 and LUT[1]=0x010 -> pc 0x010. Repeat with branch=10 for the inverse outcome.
- Load at pc 4 with mem_ready delayed 3 cycles -> mem_req high 4 cycles, pc=4 throughout, commit_en=1 only on the mem_ready cycle, then pc=5.
- Assert reset while in MEM_WAIT -> mem_req=0, pc=0, state IDLE, LUT cleared; start resumes from pc 0.
- pc=0x3FF with ALU op -> pc wraps to 0x000. Write LUT[2]=0x020 in the same cycle a branch reads index 2 -> old value is used.
